// File: rtl/condicionador_pkg.sv
// condicionador_pkg
// Shared types and defaults for the push-button conditioning stage.
//   estado_t                - FSM state codes, also shown on the hexa7seg display
//   DEBOUNCE_CICLOS_PADRAO  - default debounce window (1 ms at 50 MHz)
package condicionador_pkg;

    typedef enum logic [3:0] {
        ESPERA = 4'd0,  // idle, waiting for any button
        FILTRA = 4'd1,  // candidate sample must stay stable for the whole window
        PULSO  = 4'd2,  // one-cycle tem_jogada
        SOLTA  = 4'd3   // waiting for a debounced full release
    } estado_t;

    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff
// Two-flop synchronizer for a bus of independent asynchronous levels.
// Each bit is synchronized on its own; the bus as a whole is not coherent.
// Ports:
//   clock  - destination clock
//   reset  - asynchronous, active-low; clears both stages
//   d      - asynchronous input levels
//   q      - synchronized levels, two clock edges after d
module sincronizador_2ff #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta;

    // NOTE: clocked state always uses non-blocking assignments so that q
    // samples the old value of meta; blocking here would collapse the two
    // stages into one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes
// Synchronizes, debounces and validates the raw game buttons. Each physical
// press yields exactly one single-cycle tem_jogada pulse with a registered
// one-hot jogada code; a debounced full release is required before the next
// press is accepted.
//
// Optional feature (macro BOTOES_REJEITA_MULTIPLO_EN):
//   defined   - a debounced sample with more than one button is rejected:
//               no pulse, jogada unchanged, db_invalido pulses one cycle.
//   undefined - the lowest-index pressed button wins; db_invalido is 0.
//
// Ports:
//   clock       - system clock, rising edge
//   reset       - asynchronous, active-low
//   botoes      - raw asynchronous active-high buttons
//   jogada      - one-hot code of the last accepted press (held)
//   tem_jogada  - one-cycle pulse while in PULSO
//   db_ocupado  - high in every state except ESPERA
//   db_invalido - one-cycle pulse on a rejected multi-button press
//   db_estado   - current state code
module condicionador_botoes
    import condicionador_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] jogada,
    output logic                tem_jogada,
    output logic                db_ocupado,
    output logic                db_invalido,
    output logic [3:0]          db_estado
);

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] s;
    logic [N_BOTOES-1:0] cand;
    logic [CW-1:0]       cnt;
    estado_t             estado;

    sincronizador_2ff #(
        .LARGURA (N_BOTOES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (s)
    );

`ifdef BOTOES_REJEITA_MULTIPLO_EN
    logic invalido;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic mais_de_um(input logic [N_BOTOES-1:0] v);
        return (v & (v - N_BOTOES'(1))) != '0;
    endfunction
`else
    // Two's-complement trick: v & -v isolates the lowest set bit.
    function automatic logic [N_BOTOES-1:0] decodifica(input logic [N_BOTOES-1:0] v);
        return v & (~v + N_BOTOES'(1));
    endfunction
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= ESPERA;
            cand       <= '0;
            cnt        <= '0;
            jogada     <= '0;
            tem_jogada <= 1'b0;
`ifdef BOTOES_REJEITA_MULTIPLO_EN
            invalido   <= 1'b0;
`endif
        end else begin
            // Both pulses are single-cycle; only the accepting branch raises them.
            tem_jogada <= 1'b0;
`ifdef BOTOES_REJEITA_MULTIPLO_EN
            invalido   <= 1'b0;
`endif
            case (estado)
                ESPERA: begin
                    if (s != '0) begin
                        cand   <= s;
                        cnt    <= '0;
                        estado <= FILTRA;
                    end
                end

                FILTRA: begin
                    if (s == '0) begin
                        cnt    <= '0;
                        estado <= ESPERA;
                    end else if (s != cand) begin
                        // A change on the terminal cycle also lands here, so
                        // filtering restarts and no pulse is produced.
                        cand <= s;
                        cnt  <= '0;
                    end else if (cnt == CNT_FIM) begin
`ifdef BOTOES_REJEITA_MULTIPLO_EN
                        if (mais_de_um(cand)) begin
                            invalido <= 1'b1;
                            cnt      <= '0;
                            estado   <= SOLTA;
                        end else begin
                            jogada     <= cand;
                            tem_jogada <= 1'b1;
                            estado     <= PULSO;
                        end
`else
                        jogada     <= decodifica(cand);
                        tem_jogada <= 1'b1;
                        estado     <= PULSO;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                PULSO: begin
                    // The pulse completes even if the button was already released.
                    cnt    <= '0;
                    estado <= SOLTA;
                end

                SOLTA: begin
                    if (s != '0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_FIM) begin
                        cnt    <= '0;
                        estado <= ESPERA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    cnt    <= '0;
                    estado <= ESPERA;
                end
            endcase
        end
    end

`ifdef BOTOES_REJEITA_MULTIPLO_EN
    assign db_invalido = invalido;
`else
    assign db_invalido = 1'b0;
`endif

    // Decoded straight from the state register, so both are glitch-free
    // and zero in reset.
    assign db_ocupado = (estado != ESPERA);
    assign db_estado  = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb_condicionador_botoes
// Directed scenarios followed by a randomized button trace compared cycle by
// cycle against a run-length reference model of the conditioning rules.
// DEBOUNCE_CICLOS is set to 4 so the debounce windows stay short.
module tb_condicionador_botoes;

    localparam int N = 4;
    localparam int D = 4;
    localparam int L = 400;

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic [N-1:0] botoes = '0;
    logic [N-1:0] jogada;
    logic         tem_jogada;
    logic         db_ocupado;
    logic         db_invalido;
    logic [3:0]   db_estado;

    condicionador_botoes #(
        .N_BOTOES        (N),
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .botoes      (botoes),
        .jogada      (jogada),
        .tem_jogada  (tem_jogada),
        .db_ocupado  (db_ocupado),
        .db_invalido (db_invalido),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Random trace and expected outputs after each edge k.
    logic [N-1:0] b       [L];
    logic [N-1:0] exp_jog [L];
    logic         exp_tem [L];
    logic         exp_inv [L];
    logic [3:0]   exp_est [L];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset with buttons released; the next rising edge is edge 0.
    task automatic do_reset();
        reset  = 1'b0;
        botoes = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
        logic [N-1:0] r;
        logic         found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // The FSM sees, at edge k, the button level that was stable before edge
    // k-2. From idle, a press is accepted at the first edge ending a run of
    // D+1 identical nonzero samples; the pulse occupies that one cycle, then
    // D consecutive zero samples (starting one edge after leaving PULSO) are
    // needed before the next run may start.
    task automatic build_model();
        int           mode;  // 0 idle, 1 pulsing, 2 awaiting release
        int           run;
        int           zrun;
        logic [N-1:0] prev;
        logic [N-1:0] samp;
        logic [N-1:0] jog;
        logic [3:0]   est;
        logic         tem;
        logic         inv;
        mode = 0; run = 0; zrun = 0; prev = '0; jog = '0;
        for (int k = 0; k < L; k++) begin
            samp = (k >= 2) ? b[k-2] : '0;
            tem  = 1'b0;
            inv  = 1'b0;
            if (mode == 0) begin
                run  = (run > 0 && samp == prev) ? run + 1 : 1;
                prev = samp;
                if (samp != '0 && run >= D + 1) begin
`ifdef BOTOES_REJEITA_MULTIPLO_EN
                    if ($countones(samp) > 1) begin
                        inv  = 1'b1;
                        mode = 2;
                        zrun = 0;
                        est  = 4'd3;
                    end else begin
                        jog  = samp;
                        tem  = 1'b1;
                        mode = 1;
                        est  = 4'd2;
                    end
`else
                    jog  = lowest_bit(samp);
                    tem  = 1'b1;
                    mode = 1;
                    est  = 4'd2;
`endif
                end else begin
                    est = (samp != '0) ? 4'd1 : 4'd0;
                end
            end else if (mode == 1) begin
                mode = 2;
                zrun = 0;
                est  = 4'd3;
            end else begin
                zrun = (samp == '0) ? zrun + 1 : 0;
                if (zrun == D) begin
                    mode = 0;
                    run  = 0;
                    est  = 4'd0;
                end else begin
                    est = 4'd3;
                end
            end
            exp_jog[k] = jog;
            exp_tem[k] = tem;
            exp_inv[k] = inv;
            exp_est[k] = est;
        end
    endtask

    int           pulse_n;
    int           pulse_edge;
    int           inv_n;
    logic         ocup_ok;
    logic [N-1:0] v;
    int           seg_len;
    int           sel;

    initial begin
        // ---- reset state ----
        reset  = 1'b0;
        botoes = 4'b0101;
        repeat (3) tick();
        check("reset_jogada", jogada, 0);
        check("reset_tem", tem_jogada, 0);
        check("reset_ocupado", db_ocupado, 0);
        check("reset_invalido", db_invalido, 0);
        check("reset_estado", db_estado, 0);

        // ---- single press: latency, code, release ----
        do_reset();
        botoes     = 4'b0010;
        pulse_n    = 0;
        pulse_edge = -1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (tem_jogada === 1'b1) begin
                pulse_n++;
                pulse_edge = e;
            end
        end
        check("t1_pulses", pulse_n, 1);
        check("t1_pulse_edge", pulse_edge, D + 2);
        check("t1_jogada", jogada, 4'b0010);
        check("t1_estado_hold", db_estado, 3);
        botoes = '0;
        for (int e = 20; e <= 25; e++) begin
            tick();
            if (e == 24) check("t1_still_solta", db_estado, 3);
        end
        check("t1_back_espera", db_estado, 0);
        check("t1_ocupado_idle", db_ocupado, 0);

        // ---- reset in FILTRA with cnt=2 ----
        botoes = 4'b0001;
        for (int e = 0; e <= 4; e++) tick();
        check("rst_pre_filtra", db_estado, 1);
        #1 reset = 1'b0;
        #1;
        check("rst_jogada", jogada, 0);
        check("rst_tem", tem_jogada, 0);
        check("rst_ocupado", db_ocupado, 0);
        check("rst_estado", db_estado, 0);
        repeat (2) tick();
        reset      = 1'b1;
        pulse_n    = 0;
        pulse_edge = -1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (tem_jogada === 1'b1) begin
                pulse_n++;
                pulse_edge = e;
            end
        end
        check("rst_new_pulses", pulse_n, 1);
        check("rst_new_edge", pulse_edge, D + 2);
        check("rst_new_jogada", jogada, 4'b0001);

        // ---- long hold: single pulse, busy throughout ----
        botoes = '0;
        repeat (D + 4) tick();
        check("hold_pre_idle", db_estado, 0);
        botoes  = 4'b1000;
        pulse_n = 0;
        ocup_ok = 1'b1;
        for (int e = 0; e < 200; e++) begin
            tick();
            if (tem_jogada === 1'b1) pulse_n++;
            if (e >= 2 && db_ocupado !== 1'b1) ocup_ok = 1'b0;
        end
        check("hold_pulses", pulse_n, 1);
        check("hold_ocupado", ocup_ok, 1);
        check("hold_estado", db_estado, 3);
        check("hold_jogada", jogada, 4'b1000);

        // ---- two buttons at once ----
        botoes = '0;
        repeat (D + 4) tick();
        botoes  = 4'b0110;
        pulse_n = 0;
        inv_n   = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (tem_jogada === 1'b1) pulse_n++;
            if (db_invalido === 1'b1) inv_n++;
        end
`ifdef BOTOES_REJEITA_MULTIPLO_EN
        check("multi_pulses", pulse_n, 0);
        check("multi_invalido", inv_n, 1);
        check("multi_jogada", jogada, 4'b1000);
`else
        check("multi_pulses", pulse_n, 1);
        check("multi_invalido", inv_n, 0);
        check("multi_jogada", jogada, 4'b0010);
`endif
        check("multi_estado", db_estado, 3);

        // ---- randomized trace against the reference model ----
        begin
            int k;
            k = 0;
            while (k < L) begin
                sel = $urandom_range(0, 9);
                if (sel < 3)      v = '0;
                else if (sel < 8) v = N'(1) << $urandom_range(0, N - 1);
                else              v = N'($urandom_range(1, (1 << N) - 1));
                seg_len = $urandom_range(1, 12);
                for (int j = 0; j < seg_len && k < L; j++) begin
                    b[k] = v;
                    k++;
                end
            end
        end
        build_model();
        do_reset();
        for (int k = 0; k < L; k++) begin
            botoes = b[k];
            tick();
            check($sformatf("rnd_tem[%0d]", k), tem_jogada, exp_tem[k]);
            check($sformatf("rnd_jogada[%0d]", k), jogada, exp_jog[k]);
            check($sformatf("rnd_estado[%0d]", k), db_estado, exp_est[k]);
            check($sformatf("rnd_ocupado[%0d]", k), db_ocupado, exp_est[k] != 4'd0);
            check($sformatf("rnd_invalido[%0d]", k), db_invalido, exp_inv[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
